// File: rtl/match_referee.sv
// Rock/paper/scissors round referee: judged result 2 cycles after both moves, round_done 1 cycle later, ready again at +5.
// No backpressure: moves are latched once per round. Optional COLLECT timeout under MATCH_REFEREE_TIMEOUT_EN.
module match_referee #(
  parameter int MAX_ROUNDS = 5,
  parameter int TIMEOUT    = 64
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic [1:0] p1_move,
  input  logic       p1_valid,
  input  logic [1:0] p2_move,
  input  logic       p2_valid,
  output logic [1:0] matchresult,
  output logic       round_done,
  output logic       busy,
  output logic       game_over,
  output logic [3:0] rounds_played
);

  typedef enum logic [2:0] {
    S_IDLE, S_COLLECT, S_JUDGE, S_SETTLE, S_STROBE, S_HOLD, S_DONE
  } state_t;

  state_t     r_state, w_next;
  logic       r_p1_full, r_p2_full;
  logic [1:0] r_p1_mv, r_p2_mv;
  logic       w_p1_take, w_p2_take, w_timeout;
  logic [1:0] w_judged;

  assign w_p1_take = (r_state == S_COLLECT) && !r_p1_full && p1_valid && (p1_move != 2'b00);
  assign w_p2_take = (r_state == S_COLLECT) && !r_p2_full && p2_valid && (p2_move != 2'b00);

`ifdef MATCH_REFEREE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT) + 1;
  logic [CW-1:0] r_to_cnt;

  // Held at zero outside COLLECT, so every entry starts a fresh count.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                    r_to_cnt <= '0;
    else if (r_state != S_COLLECT)  r_to_cnt <= '0;
    else                            r_to_cnt <= r_to_cnt + 1'b1;
  end

  assign w_timeout = (r_state == S_COLLECT) && (r_to_cnt == CW'(TIMEOUT - 1));
`else
  assign w_timeout = 1'b0;
  if (TIMEOUT < 1) begin : g_timeout_inactive
  end
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start) w_next = S_COLLECT;
      S_COLLECT: if ((r_p1_full && r_p2_full) || w_timeout) w_next = S_JUDGE;
      S_JUDGE:   w_next = S_SETTLE;
      S_SETTLE:  w_next = S_STROBE;
      S_STROBE:  w_next = S_HOLD;
      S_HOLD:    w_next = (rounds_played == 4'(MAX_ROUNDS)) ? S_DONE : S_COLLECT;
      S_DONE:    if (start) w_next = S_COLLECT;
      default:   w_next = S_IDLE;
    endcase
  end

  // A missing move forfeits the round to whoever did play.
  always_comb begin
    w_judged = 2'b00;
    if (r_p1_full && r_p2_full) begin
      if (r_p1_mv != r_p2_mv) begin
        if ((r_p1_mv == 2'b01 && r_p2_mv == 2'b11) ||
            (r_p1_mv == 2'b11 && r_p2_mv == 2'b10) ||
            (r_p1_mv == 2'b10 && r_p2_mv == 2'b01))
          w_judged = 2'b01;
        else
          w_judged = 2'b11;
      end
    end else if (r_p1_full) begin
      w_judged = 2'b01;
    end else if (r_p2_full) begin
      w_judged = 2'b11;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_p1_full <= 1'b0;
      r_p2_full <= 1'b0;
      r_p1_mv   <= 2'b00;
      r_p2_mv   <= 2'b00;
    end else if (r_state == S_HOLD) begin
      r_p1_full <= 1'b0;
      r_p2_full <= 1'b0;
      r_p1_mv   <= 2'b00;
      r_p2_mv   <= 2'b00;
    end else begin
      if (w_p1_take) begin
        r_p1_full <= 1'b1;
        r_p1_mv   <= p1_move;
      end
      if (w_p2_take) begin
        r_p2_full <= 1'b1;
        r_p2_mv   <= p2_move;
      end
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      matchresult   <= 2'b00;
      round_done    <= 1'b0;
      busy          <= 1'b0;
      game_over     <= 1'b0;
      rounds_played <= 4'd0;
    end else begin
      round_done <= (w_next == S_STROBE);
      busy       <= (w_next != S_IDLE) && (w_next != S_DONE);
      game_over  <= (w_next == S_DONE);
      if (w_next == S_COLLECT)      matchresult <= 2'b00;
      else if (r_state == S_JUDGE)  matchresult <= w_judged;
      if (r_state == S_IDLE || (r_state == S_DONE && start))
        rounds_played <= 4'd0;
      else if (r_state == S_STROBE)
        rounds_played <= rounds_played + 4'd1;
    end
  end

endmodule

// File: tb/tb_match_referee.sv
// Directed bench for match_referee: game sequencing, move latching, result timing and async reset.
module tb_match_referee;

  logic       clk;
  logic       resetn;
  logic       start;
  logic [1:0] p1_move, p2_move;
  logic       p1_valid, p2_valid;
  logic [1:0] matchresult;
  logic       round_done, busy, game_over;
  logic [3:0] rounds_played;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int pulses_before = 0;

  match_referee #(.MAX_ROUNDS(5), .TIMEOUT(8)) dut (
    .clk(clk), .resetn(resetn), .start(start),
    .p1_move(p1_move), .p1_valid(p1_valid),
    .p2_move(p2_move), .p2_valid(p2_valid),
    .matchresult(matchresult), .round_done(round_done),
    .busy(busy), .game_over(game_over), .rounds_played(rounds_played)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) if (round_done === 1'b1) pulses++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered just after the edge that latched the last move.
  task automatic finish_round(input logic [1:0] exp_mr, input logic [3:0] exp_rounds);
    step();
    chk("judge_mr_forced0", 32'(matchresult), 32'd0);
    step();
    chk("settle_mr", 32'(matchresult), 32'(exp_mr));
    chk("settle_rd", 32'(round_done), 32'd0);
    step();
    chk("strobe_rd", 32'(round_done), 32'd1);
    chk("strobe_mr", 32'(matchresult), 32'(exp_mr));
    step();
    chk("hold_rd", 32'(round_done), 32'd0);
    chk("hold_rounds", 32'(rounds_played), 32'(exp_rounds));
    step();
  endtask

  task automatic play_round(input logic [1:0] m1, input logic [1:0] m2,
                            input logic [1:0] exp_mr, input logic [3:0] exp_rounds);
    p1_move = m1; p1_valid = 1'b1;
    p2_move = m2; p2_valid = 1'b1;
    step();
    p1_valid = 1'b0; p2_valid = 1'b0;
    chk("latched_mr", 32'(matchresult), 32'd0);
    finish_round(exp_mr, exp_rounds);
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0;
    p1_move = 2'b00; p2_move = 2'b00; p1_valid = 1'b0; p2_valid = 1'b0;
    #12;
    chk("rst_mr", 32'(matchresult), 32'd0);
    chk("rst_rd", 32'(round_done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_go", 32'(game_over), 32'd0);
    chk("rst_rounds", 32'(rounds_played), 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    step();
    chk("idle_busy", 32'(busy), 32'd0);

    start = 1'b1; step(); start = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_rounds", 32'(rounds_played), 32'd0);

    // Round 1: rock vs scissors.
    play_round(2'b01, 2'b11, 2'b01, 4'd1);
    chk("r1_back_collect_mr", 32'(matchresult), 32'd0);
    chk("r1_busy", 32'(busy), 32'd1);

    // Round 2: p2 paper, p2 change to rock ignored, illegal p1 ignored, p1 rock.
    p2_move = 2'b10; p2_valid = 1'b1; step();
    p2_move = 2'b01; step();
    p2_valid = 1'b0;
    p1_move = 2'b00; p1_valid = 1'b1; step();
    p1_valid = 1'b0;
    step(); step();
    chk("illegal_no_judge_mr", 32'(matchresult), 32'd0);
    chk("illegal_busy", 32'(busy), 32'd1);
    p1_move = 2'b01; p1_valid = 1'b1; step();
    p1_valid = 1'b0;
    finish_round(2'b11, 4'd2);
    chk("r2_pulses", 32'(pulses), 32'd2);

    // Start while busy must not restart the game.
    start = 1'b1; step(); start = 1'b0;
    chk("busy_start_rounds", 32'(rounds_played), 32'd2);
    chk("busy_start_busy", 32'(busy), 32'd1);

    play_round(2'b10, 2'b10, 2'b00, 4'd3);
    play_round(2'b11, 2'b10, 2'b01, 4'd4);
    play_round(2'b10, 2'b01, 2'b01, 4'd5);
    chk("done_go", 32'(game_over), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_rounds", 32'(rounds_played), 32'd5);
    chk("done_mr_held", 32'(matchresult), 32'd1);
    chk("done_pulses", 32'(pulses), 32'd5);
    p1_move = 2'b01; p1_valid = 1'b1; p2_move = 2'b11; p2_valid = 1'b1;
    step(); step();
    p1_valid = 1'b0; p2_valid = 1'b0;
    chk("done_stays_go", 32'(game_over), 32'd1);
    chk("done_stays_pulses", 32'(pulses), 32'd5);

    start = 1'b1; step(); start = 1'b0;
    chk("restart_rounds", 32'(rounds_played), 32'd0);
    chk("restart_go", 32'(game_over), 32'd0);
    chk("restart_busy", 32'(busy), 32'd1);
    chk("restart_mr", 32'(matchresult), 32'd0);

    // Async reset in the middle of the strobe cycle.
    p1_move = 2'b01; p1_valid = 1'b1; p2_move = 2'b11; p2_valid = 1'b1;
    step();
    p1_valid = 1'b0; p2_valid = 1'b0;
    step(); step(); step();
    chk("pre_reset_rd", 32'(round_done), 32'd1);
    chk("pre_reset_mr", 32'(matchresult), 32'd1);
    #1 resetn = 1'b0;
    #1;
    chk("async_rst_rd", 32'(round_done), 32'd0);
    chk("async_rst_mr", 32'(matchresult), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_rounds", 32'(rounds_played), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    step(); step();
    chk("post_reset_idle_busy", 32'(busy), 32'd0);
    chk("post_reset_pulses", 32'(pulses), 32'd5);

    start = 1'b1; step(); start = 1'b0;
`ifdef MATCH_REFEREE_TIMEOUT_EN
    // Only p1 plays: forced p1 win after 8 COLLECT cycles.
    p1_move = 2'b01; p1_valid = 1'b1; step();
    p1_valid = 1'b0;
    repeat (6) step();
    chk("to_waiting_mr", 32'(matchresult), 32'd0);
    chk("to_waiting_busy", 32'(busy), 32'd1);
    chk("to_waiting_rd", 32'(round_done), 32'd0);
    step();
    step();
    chk("to_p1_mr", 32'(matchresult), 32'd1);
    chk("to_p1_settle_rd", 32'(round_done), 32'd0);
    step();
    chk("to_p1_rd", 32'(round_done), 32'd1);
    step();
    chk("to_p1_rounds", 32'(rounds_played), 32'd1);
    step();
    chk("to_p1_collect_mr", 32'(matchresult), 32'd0);
    // Nobody plays: forced draw, still a strobe.
    pulses_before = pulses;
    repeat (9) step();
    chk("to_none_mr", 32'(matchresult), 32'd0);
    chk("to_none_settle_rd", 32'(round_done), 32'd0);
    step();
    chk("to_none_rd", 32'(round_done), 32'd1);
    step();
    chk("to_none_rounds", 32'(rounds_played), 32'd2);
    chk("to_none_pulses", 32'(pulses), 32'(pulses_before + 1));
`else
    pulses_before = pulses;
    repeat (1000) step();
    chk("wait_no_pulse", 32'(pulses), 32'(pulses_before));
    chk("wait_busy", 32'(busy), 32'd1);
    chk("wait_rd", 32'(round_done), 32'd0);
    chk("wait_rounds", 32'(rounds_played), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/match_referee.md
Name: match_referee

Overview:
- Producer side of the round-result interface consumed by the score-update block.
- Collects one move per player per round (rock/paper/scissors) and judges the round.
- Drives the 2-bit matchresult code, then a single registered round_done pulse; round_done is the score block's clock.
- Sequences up to MAX_ROUNDS rounds per game, then asserts game_over.

Parameters:
- MAX_ROUNDS, 5, rounds per game; legal range 1..15, matching the 4-bit score counters.
- TIMEOUT, 64, COLLECT-state cycle limit; used only with MATCH_REFEREE_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- resetn  in  1  reset, asynchronous and active-low.
- start  in  1  single-cycle game start; honoured only in IDLE or DONE.
- p1_move  in  2  player-1 move: 01 rock, 10 paper, 11 scissors, 00 illegal.
- p1_valid  in  1  player-1 move strobe.
- p2_move  in  2  player-2 move, same encoding as p1_move.
- p2_valid  in  1  player-2 move strobe.
- matchresult  out  2  round result: 01 player-1 win, 11 player-2 win, 00 draw/none; 10 is never driven.
- round_done  out  1  one-cycle registered strobe, end of round.
- busy  out  1  high in every state except IDLE and DONE.
- game_over  out  1  high in DONE.
- rounds_played  out  4  number of completed rounds in the current game.

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE.
  - matchresult=00, round_done=0, busy=0, game_over=0, rounds_played=0.
  - Both move latches cleared.
  - Applies immediately, including mid-round or mid-strobe.
- All outputs are registered; none is combinational from the inputs.
- States: IDLE, COLLECT, JUDGE, SETTLE, STROBE, HOLD, DONE.
- IDLE:
  - start=1 -> COLLECT.
  - rounds_played cleared to 0.
- COLLECT:
  - A player's move is latched the first cycle its valid=1 with move!=00.
  - Later valids from that player are ignored (no change of mind).
  - A valid with move=00 is ignored.
  - Simultaneous p1/p2 valids in one cycle are both latched.
  - Leave for JUDGE on the edge after both latches are full.
  - matchresult is forced to 00 for the whole state.
- JUDGE (1 cycle), result registered on exit:
  - Equal moves -> 00.
  - Rock beats scissors, scissors beats paper, paper beats rock.
  - Player-1 win -> 01, player-2 win -> 11.
- SETTLE (1 cycle): matchresult stable, round_done=0; gives setup time for the gated score clocks.
- STROBE (1 cycle):
  - round_done=1, matchresult unchanged.
  - rounds_played increments on exit.
- HOLD (1 cycle):
  - round_done=0, matchresult still held.
  - Clear both latches.
  - If rounds_played==MAX_ROUNDS -> DONE, else -> COLLECT.
- Latency: with both moves sampled at edge k:
  - matchresult valid from cycle k+2.
  - round_done high in cycle k+3 only.
  - COLLECT (or DONE) re-entered at cycle k+5.
- Draws still produce a round_done pulse and count as a round.
- DONE:
  - game_over=1; matchresult holds the last result.
  - start=1 -> COLLECT; on that transition rounds_played=0 and game_over=0.
- start is ignored in every state other than IDLE and DONE.
- rounds_played never wraps: MAX_ROUNDS<=15 and DONE is terminal until the next start.

Optional Feature:
- Macro: MATCH_REFEREE_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in COLLECT, cleared on entry.
  - If the counter reaches TIMEOUT-1 without both latches full, go to JUDGE with a forced result.
  - Only p1 latched -> 01; only p2 latched -> 11; neither latched -> 00.
  - A move arriving in the same cycle as the timeout is still latched before the forced result is decided.
- Undefined: no counter; COLLECT waits indefinitely; TIMEOUT is unused.

Test Plan:
- Basic win: reset, start, p1=rock and p2=scissors in the same cycle -> matchresult=01 two cycles later; round_done high exactly one cycle later; rounds_played=1.
- Ordering/ignore: p2=paper first, then a second p2=rock, then p1=rock -> second p2 ignored; matchresult=11; an illegal 00 move with valid never latches.
- Full game: MAX_ROUNDS=5 with results win, lose, draw, win, win -> five round_done pulses; game_over=1, rounds_played=5; start ignored while busy=1; start in DONE restarts with rounds_played=0.
- Reset mid-strobe: assert resetn=0 during STROBE -> round_done=0, matchresult=00, state IDLE immediately, without waiting for clk.
- Timeout (macro defined, TIMEOUT=8): only p1 moves -> forced matchresult=01 after 8 COLLECT cycles; no moves at all -> 00 with a round_done pulse.
- Macro undefined: 1000 idle cycles in COLLECT -> no round_done, busy stays 1.
